spi_sched: RTL

Shares one SPI master bus (CPOL 0, MSB-first, 8-bit frames, per-transfer CPHA) between `NREQ` requesters, each with its own active-low chip select. It arbitrates among pending requests, sequences the chip select, SCLK and shift timing for the winner, and returns the received byte with a done pulse. It sits above the SPI slave peripherals and drives their `clk`/`cs`/`mosi` pins while sampling `miso`.

---
 rtl/spi_sched.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/spi_sched.sv
// rtl/spi_sched.sv - SPI master bus scheduler shared by NREQ requesters (option: SPI_SCHED_RR_EN)
module spi_sched #(
  parameter int NREQ    = 2,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_cpha,
  output logic [NREQ-1:0]   grant,
  output logic              done,
  output logic [7:0]        rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NREQ-1:0]   cs
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            cnt_last;
  logic [3:0]      half;
  logic [3:0]      half_next;
  logic [7:0]      sr;
  logic            samp;
  logic            cpha;
  logic [IW-1:0]   win;
  logic            found;
  logic [NREQ-1:0] win_onehot;

  assign cnt_last   = (cnt == CNT_LAST);
  assign half_next  = half + 4'd1;
  assign win_onehot = NREQ'(1) << win;
  // The outgoing bit is always the top of the shift register.
  assign mosi       = sr[7];

`ifdef SPI_SCHED_RR_EN
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;

  // Round-robin pick: scan upward from the pointer, first pending requester wins.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        win   = IW'(idx);
        found = 1'b1;
      end
    end
  end
`else
  // Fixed priority pick: lowest pending index wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[k]) begin
        win   = IW'(k);
        found = 1'b1;
      end
    end
  end
`endif

  // Transfer sequencer; every output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      half    <= '0;
      sr      <= '0;
      samp    <= 1'b0;
      cpha    <= 1'b0;
      cs      <= '1;
      grant   <= '0;
      sclk    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      rx_data <= '0;
`ifdef SPI_SCHED_RR_EN
      ptr     <= '0;
      owner   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            sr    <= req_data[8*win +: 8];
            cpha  <= req_cpha[win];
            cs    <= ~win_onehot;
            grant <= win_onehot;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= LEAD;
`ifdef SPI_SCHED_RR_EN
            owner <= win;
`endif
          end
        end
        LEAD: begin
          if (cnt_last) begin
            // First rise happens here; CPHA 0 captures its first bit on it.
            cnt   <= '0;
            half  <= '0;
            sclk  <= 1'b1;
            state <= SHIFT;
            if (!cpha) samp <= miso;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt_last) begin
            cnt <= '0;
            if (half == 4'd15) begin
              state <= TRAIL;
            end else begin
              half <= half_next;
              sclk <= ~sclk;
              if (!half_next[0]) begin
                // Rising edge.
                if (cpha) sr <= {sr[6:0], samp};
                else      samp <= miso;
              end else begin
                // Falling edge; CPHA 0 skips the shift on the final fall.
                if (cpha)                    samp <= miso;
                else if (half_next != 4'd15) sr <= {sr[6:0], samp};
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TRAIL: begin
          if (cnt_last) begin
            // Seven bits are already in the register; the eighth is still in samp.
            cnt     <= '0;
            cs      <= '1;
            grant   <= '0;
            done    <= 1'b1;
            rx_data <= {sr[6:0], samp};
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
`ifdef SPI_SCHED_RR_EN
          ptr   <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
